// File: rtl/osd_dii_pkg.sv
// Shared definitions for the DII debug-interconnect blocks: flit width and
// the packet arbiter state encoding.
package osd_dii_pkg;

  localparam int DII_FLIT_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    DROP
  } arb_state_t;

endpackage

// File: rtl/dii_rr_select.sv
// Combinational round-robin pick: the first requester found after ptr,
// wrapping modulo PORTS, wins.
module dii_rr_select
  import osd_dii_pkg::*;
#(
  parameter int PORTS = 3,
  parameter int IW    = (PORTS > 1) ? $clog2(PORTS) : 1
) (
  input  logic [PORTS-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [PORTS-1:0] gnt,
  output logic [IW-1:0]    idx
);

  always_comb begin
    logic          found;
    logic [IW-1:0] cand;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    // Offset PORTS lands back on ptr itself, so the last owner gets the lowest priority.
    for (int k = 1; k <= PORTS; k++) begin
      cand = IW'((int'(ptr) + k) % PORTS);
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/dii_packet_arbiter.sv
// Packet-granular round-robin arbiter sharing one registered DII output
// stream between PORTS requesters, with maximum-length truncation.
module dii_packet_arbiter
  import osd_dii_pkg::*;
#(
  parameter int PORTS   = 3,
  parameter int MAX_LEN = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [PORTS*DII_FLIT_W-1:0] in_data,
  input  logic [PORTS-1:0]            in_last,
  input  logic [PORTS-1:0]            in_valid,
  output logic [PORTS-1:0]            in_ready,
  output logic [DII_FLIT_W-1:0]       out_data,
  output logic                        out_last,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [PORTS-1:0]            grant,
  output logic                        err_overlen
);

  localparam int IW = (PORTS > 1) ? $clog2(PORTS) : 1;
  localparam int CW = $clog2(MAX_LEN);
  localparam logic [CW-1:0] LAST_CNT = CW'(MAX_LEN - 1);

  arb_state_t            state, state_nxt;
  logic [PORTS-1:0]      grant_q, sel_gnt;
  logic [IW-1:0]         ptr, sel_idx;
  logic [CW-1:0]         cnt;
  logic [DII_FLIT_W-1:0] beat_data;
  logic                  beat_valid, beat_last;
  logic                  load_ok, xfer_ok, accept, at_max, overlen;

  dii_rr_select #(
    .PORTS(PORTS),
    .IW   (IW)
  ) u_sel (
    .req(in_valid),
    .ptr(ptr),
    .gnt(sel_gnt),
    .idx(sel_idx)
  );

  // Route the granted requester's beat; the grant is one-hot or zero.
  always_comb begin
    beat_data  = '0;
    beat_valid = 1'b0;
    beat_last  = 1'b0;
    for (int i = 0; i < PORTS; i++) begin
      if (grant_q[i]) begin
        beat_data  = in_data[i*DII_FLIT_W +: DII_FLIT_W];
        beat_valid = in_valid[i];
        beat_last  = in_last[i];
      end
    end
  end

  assign load_ok = ~out_valid | out_ready;
  assign at_max  = (cnt == LAST_CNT);
  assign accept  = beat_valid & xfer_ok;
  assign overlen = (state == XFER) & accept & ~beat_last & at_max;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (|in_valid) state_nxt = XFER;
      XFER: begin
        if (accept) begin
          if (beat_last)   state_nxt = IDLE;
          else if (at_max) state_nxt = DROP;
        end
      end
      DROP: if (accept && beat_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    unique case (state)
      XFER:    xfer_ok = load_ok;
      DROP:    xfer_ok = 1'b1;
      default: xfer_ok = 1'b0;
    endcase
    in_ready = grant_q & {PORTS{xfer_ok}};
  end

  assign grant = grant_q;

  // Returning to IDLE always drops the grant, which forces the inter-packet gap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_q <= '0;
      ptr     <= IW'(PORTS - 1);
      cnt     <= '0;
    end else if (state == IDLE && |in_valid) begin
      grant_q <= sel_gnt;
      ptr     <= sel_idx;
      cnt     <= '0;
    end else if (state != IDLE && state_nxt == IDLE) begin
      grant_q <= '0;
    end else if (state == XFER && accept && !at_max) begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
      out_data    <= '0;
      err_overlen <= 1'b0;
    end else begin
      err_overlen <= overlen;
      if (state == XFER && accept) begin
        out_valid <= 1'b1;
        out_data  <= beat_data;
        out_last  <= beat_last | at_max;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dii_packet_arbiter.sv
// Self-checking bench for dii_packet_arbiter (PORTS=3, MAX_LEN=4): cycle
// vector table plus queue-driven multi-packet sequences.
module tb_dii_packet_arbiter;

  localparam int PORTS   = 3;
  localparam int MAX_LEN = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [47:0] in_data = '0;
  logic [2:0]  in_last = '0;
  logic [2:0]  in_valid = '0;
  logic [2:0]  in_ready;
  logic [15:0] out_data;
  logic        out_last, out_valid;
  logic        out_ready = 1'b1;
  logic [2:0]  grant;
  logic        err_overlen;

  int passCnt = 0;
  int totalCnt = 0;

  typedef struct {
    string       name;
    logic [2:0]  vld;
    logic [2:0]  lst;
    logic [47:0] dat;
    logic        rdy;
    logic [2:0]  eGrant;
    logic [2:0]  eReady;
    logic        eValid;
    logic [15:0] eData;
    logic        eLast;
    logic        eErr;
  } vec_t;

  vec_t        vecs[$];
  logic [16:0] srcQ[PORTS][$];
  logic [15:0] outD[$];
  logic        outL[$];
  logic [16:0] expQ[$];
  logic [2:0]  grantLog[$];
  logic [2:0]  expGrant[$];
  int          gapLog[$];
  logic        rdyPat[$];
  logic        prevStall;
  logic [15:0] prevData;
  logic        prevLast;
  logic [2:0]  prevGrant;
  int          idleCnt;
  int          errCnt;

  dii_packet_arbiter #(
    .PORTS  (PORTS),
    .MAX_LEN(MAX_LEN)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_last    (in_last),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .grant      (grant),
    .err_overlen(err_overlen)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
  endtask

  function automatic vec_t mk(input string nm, input logic [2:0] vld, input logic [2:0] lst,
                              input logic [47:0] dat, input logic rdy, input logic [2:0] eg,
                              input logic [2:0] er, input logic ev, input logic [15:0] ed,
                              input logic el, input logic ee);
    vec_t v;
    v.name = nm; v.vld = vld; v.lst = lst; v.dat = dat; v.rdy = rdy;
    v.eGrant = eg; v.eReady = er; v.eValid = ev; v.eData = ed; v.eLast = el; v.eErr = ee;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    in_valid  = v.vld;
    in_last   = v.lst;
    in_data   = v.dat;
    out_ready = v.rdy;
  endtask

  task automatic checkOutput(input vec_t v);
    check({v.name, "_grant"}, 64'(grant), 64'(v.eGrant));
    check({v.name, "_in_ready"}, 64'(in_ready), 64'(v.eReady));
    check({v.name, "_out_valid"}, 64'(out_valid), 64'(v.eValid));
    check({v.name, "_err"}, 64'(err_overlen), 64'(v.eErr));
    if (v.eValid) check({v.name, "_out_beat"}, 64'({out_last, out_data}), 64'({v.eLast, v.eData}));
  endtask

  task automatic clearMon();
    outD.delete(); outL.delete(); expQ.delete(); grantLog.delete();
    expGrant.delete(); gapLog.delete(); rdyPat.delete();
    for (int p = 0; p < PORTS; p++) srcQ[p].delete();
    prevStall = 1'b0; prevData = '0; prevLast = 1'b0; prevGrant = '0;
    idleCnt = 0; errCnt = 0;
  endtask

  task automatic addPkt(input int p, input logic [15:0] base, input int len);
    for (int i = 0; i < len; i++) srcQ[p].push_back({(i == len - 1), base + 16'(i)});
  endtask

  task automatic addExp(input logic [15:0] base, input int len);
    for (int i = 0; i < len; i++) expQ.push_back({(i == len - 1), base + 16'(i)});
  endtask

  function automatic bit srcEmpty();
    for (int p = 0; p < PORTS; p++) if (srcQ[p].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  // One clock of queue-driven stimulus; starts and ends 1 time unit after posedge.
  task automatic autoCycle(input logic rdy);
    logic [2:0] acc;
    out_ready = rdy;
    for (int p = 0; p < PORTS; p++) begin
      if (srcQ[p].size() != 0) begin
        in_valid[p] = 1'b1;
        in_last[p]  = srcQ[p][0][16];
        in_data[p*16 +: 16] = srcQ[p][0][15:0];
      end else begin
        in_valid[p] = 1'b0;
        in_last[p]  = 1'b0;
      end
    end
    #4;
    acc = in_valid & in_ready;
    if ((in_valid & ~grant) != '0) check("nongrant_ready", 64'(in_ready & ~grant), 64'(0));
    if (prevStall) check("stall_hold", 64'({out_valid, out_last, out_data}), 64'({1'b1, prevLast, prevData}));
    prevStall = out_valid && !out_ready;
    prevData  = out_data;
    prevLast  = out_last;
    if (out_valid && out_ready) begin
      outD.push_back(out_data);
      outL.push_back(out_last);
    end
    if (err_overlen) errCnt++;
    if (grant != '0 && grant != prevGrant) begin
      if (grantLog.size() != 0) gapLog.push_back(idleCnt);
      grantLog.push_back(grant);
      idleCnt = 0;
    end else if (grant == '0) begin
      idleCnt++;
    end
    prevGrant = grant;
    @(posedge clk);
    #1;
    for (int p = 0; p < PORTS; p++) if (acc[p]) void'(srcQ[p].pop_front());
  endtask

  task automatic runAuto(input int expBeats, input int maxCyc);
    int n;
    n = 0;
    while ((!srcEmpty() || outD.size() < expBeats || grant != '0 || out_valid) && n < maxCyc) begin
      autoCycle((n < rdyPat.size()) ? rdyPat[n] : 1'b1);
      n++;
    end
    check("run_timeout", 64'(n < maxCyc), 64'(1));
  endtask

  task automatic verifyRun(input string tag);
    check({tag, "_beats"}, 64'(outD.size()), 64'(expQ.size()));
    for (int i = 0; i < expQ.size() && i < outD.size(); i++)
      check({tag, "_beat"}, 64'({outL[i], outD[i]}), 64'(expQ[i]));
    check({tag, "_grants"}, 64'(grantLog.size()), 64'(expGrant.size()));
    for (int i = 0; i < expGrant.size() && i < grantLog.size(); i++)
      check({tag, "_grant_order"}, 64'(grantLog[i]), 64'(expGrant[i]));
    for (int i = 0; i < gapLog.size(); i++) check({tag, "_gap"}, 64'(gapLog[i]), 64'(1));
    check({tag, "_err_pulses"}, 64'(errCnt), 64'(0));
  endtask

  initial begin
    // Port 1 three-beat packet, then port 2 six-beat packet truncated at 4 beats.
    vecs.push_back(mk("a0", 3'b010, 3'b000, {16'h0, 16'h1001, 16'h0}, 1'b1, 3'b000, 3'b000, 1'b0, 16'h0,    1'b0, 1'b0));
    vecs.push_back(mk("a1", 3'b010, 3'b000, {16'h0, 16'h1001, 16'h0}, 1'b1, 3'b010, 3'b010, 1'b0, 16'h0,    1'b0, 1'b0));
    vecs.push_back(mk("a2", 3'b010, 3'b000, {16'h0, 16'h1002, 16'h0}, 1'b1, 3'b010, 3'b010, 1'b1, 16'h1001, 1'b0, 1'b0));
    vecs.push_back(mk("a3", 3'b010, 3'b010, {16'h0, 16'h1003, 16'h0}, 1'b1, 3'b010, 3'b010, 1'b1, 16'h1002, 1'b0, 1'b0));
    vecs.push_back(mk("a4", 3'b000, 3'b000, 48'h0,                    1'b1, 3'b000, 3'b000, 1'b1, 16'h1003, 1'b1, 1'b0));
    vecs.push_back(mk("a5", 3'b000, 3'b000, 48'h0,                    1'b1, 3'b000, 3'b000, 1'b0, 16'h0,    1'b0, 1'b0));
    vecs.push_back(mk("b0", 3'b100, 3'b000, {16'h2001, 32'h0},        1'b1, 3'b000, 3'b000, 1'b0, 16'h0,    1'b0, 1'b0));
    vecs.push_back(mk("b1", 3'b100, 3'b000, {16'h2001, 32'h0},        1'b1, 3'b100, 3'b100, 1'b0, 16'h0,    1'b0, 1'b0));
    vecs.push_back(mk("b2", 3'b100, 3'b000, {16'h2002, 32'h0},        1'b1, 3'b100, 3'b100, 1'b1, 16'h2001, 1'b0, 1'b0));
    vecs.push_back(mk("b3", 3'b100, 3'b000, {16'h2003, 32'h0},        1'b1, 3'b100, 3'b100, 1'b1, 16'h2002, 1'b0, 1'b0));
    vecs.push_back(mk("b4", 3'b100, 3'b000, {16'h2004, 32'h0},        1'b1, 3'b100, 3'b100, 1'b1, 16'h2003, 1'b0, 1'b0));
    vecs.push_back(mk("b5", 3'b100, 3'b000, {16'h2005, 32'h0},        1'b1, 3'b100, 3'b100, 1'b1, 16'h2004, 1'b1, 1'b1));
    vecs.push_back(mk("b6", 3'b100, 3'b100, {16'h2006, 32'h0},        1'b1, 3'b100, 3'b100, 1'b0, 16'h0,    1'b0, 1'b0));
    vecs.push_back(mk("b7", 3'b000, 3'b000, 48'h0,                    1'b1, 3'b000, 3'b000, 1'b0, 16'h0,    1'b0, 1'b0));

    clearMon();
    in_valid = 3'b111;
    @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_last", 64'(out_last), 64'(0));
    check("rst_out_data", 64'(out_data), 64'(0));
    check("rst_grant", 64'(grant), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(0));
    check("rst_err", 64'(err_overlen), 64'(0));
    in_valid = '0;
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      #4;
      checkOutput(vecs[i]);
      @(posedge clk);
      #1;
    end

    // All three ports request at reset release: strict rotation with one idle cycle between packets.
    rst = 1'b1;
    clearMon();
    @(posedge clk);
    #1;
    addPkt(0, 16'h0A01, 2); addPkt(0, 16'h0D01, 2);
    addPkt(1, 16'h1B01, 2); addPkt(2, 16'h2C01, 2);
    addExp(16'h0A01, 2); addExp(16'h1B01, 2); addExp(16'h2C01, 2); addExp(16'h0D01, 2);
    expGrant.push_back(3'b001); expGrant.push_back(3'b010);
    expGrant.push_back(3'b100); expGrant.push_back(3'b001);
    rst = 1'b0;
    runAuto(8, 200);
    verifyRun("rr");

    // Downstream stall mid-packet; last beat lands exactly on MAX_LEN.
    clearMon();
    addPkt(0, 16'h3001, 4);
    addExp(16'h3001, 4);
    expGrant.push_back(3'b001);
    rdyPat.push_back(1'b1); rdyPat.push_back(1'b1); rdyPat.push_back(1'b1);
    rdyPat.push_back(1'b0); rdyPat.push_back(1'b0); rdyPat.push_back(1'b1);
    runAuto(4, 100);
    verifyRun("stall");

    // Asynchronous reset two beats into a five-beat packet on port 1.
    clearMon();
    addPkt(1, 16'h4001, 5);
    for (int k = 0; k < 3; k++) autoCycle(1'b1);
    rst = 1'b1;
    #1;
    check("async_rst_out_valid", 64'(out_valid), 64'(0));
    check("async_rst_grant", 64'(grant), 64'(0));
    check("async_rst_in_ready", 64'(in_ready), 64'(0));
    @(posedge clk);
    #1;
    clearMon();
    in_valid = '0; in_last = '0; in_data = '0;
    addPkt(0, 16'h5001, 1); addPkt(2, 16'h5201, 1);
    addExp(16'h5001, 1); addExp(16'h5201, 1);
    expGrant.push_back(3'b001); expGrant.push_back(3'b100);
    rst = 1'b0;
    runAuto(2, 100);
    verifyRun("post_rst");

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
